// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter - round-robin sharing of one C2 memory port by two caches
// Rev 1.0
// ============================================================================
module mem_bus_arbiter #(
    parameter int BUS_SIZE   = 16,
    parameter int ADDR_W     = 15,
    parameter int LINE_BEATS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req0_cmd,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [BUS_SIZE-1:0] req0_wdata,
    input  logic [1:0]          req1_cmd,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [BUS_SIZE-1:0] req1_wdata,
    output logic [1:0]          req_gnt,
    output logic [1:0]          req0_rsp_cmd,
    output logic [BUS_SIZE-1:0] req0_rdata,
    output logic [1:0]          req1_rsp_cmd,
    output logic [BUS_SIZE-1:0] req1_rdata,
    output logic                busy,
    output logic [1:0]          mem_cmd_out,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [BUS_SIZE-1:0] mem_data_out,
    input  logic [1:0]          mem_cmd_in,
    input  logic [BUS_SIZE-1:0] mem_data_in
);

    localparam int CNT_W = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(LINE_BEATS - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    localparam logic [1:0] c_nop      = 2'd0;
    localparam logic [1:0] c_response = 2'd1;
    localparam logic [1:0] c_read     = 2'd2;
    localparam logic [1:0] c_write    = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD       = 3'd1,
        WR_BEATS  = 3'd2,
        WAIT_RESP = 3'd3,
        RD_BEATS  = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_owner;
    logic                  r_last_owner;
    logic [1:0]            r_cmd_q;
    logic [ADDR_W-1:0]     r_addr_q;
    logic [BUS_SIZE-1:0]   r_beat0_q;
    logic [CNT_W-1:0]      r_beat_cnt;

    logic w_v0;
    logic w_v1;
    logic w_win;

    assign w_v0  = (req0_cmd == c_read) || (req0_cmd == c_write);
    assign w_v1  = (req1_cmd == c_read) || (req1_cmd == c_write);
    // On a tie the requester that did not own the bus last time wins.
    assign w_win = (w_v0 && w_v1) ? ~r_last_owner : w_v1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_cmd_q      <= c_nop;
            r_addr_q     <= '0;
            r_beat0_q    <= '0;
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_v0 || w_v1) begin
                        r_owner      <= w_win;
                        r_last_owner <= w_win;
                        r_cmd_q      <= w_win ? req1_cmd   : req0_cmd;
                        r_addr_q     <= w_win ? req1_addr  : req0_addr;
                        r_beat0_q    <= w_win ? req1_wdata : req0_wdata;
                        r_state      <= CMD;
                    end
                end
                CMD: begin
                    if (r_cmd_q == c_write) begin
                        r_beat_cnt <= c_one;
                        r_state    <= WR_BEATS;
                    end else begin
                        r_state    <= WAIT_RESP;
                    end
                end
                WR_BEATS: begin
                    r_beat_cnt <= r_beat_cnt + c_one;
                    if (r_beat_cnt == c_last_beat) r_state <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (mem_cmd_in == c_response) begin
                        if (r_cmd_q == c_write) begin
                            r_state <= IDLE;
                        end else begin
                            // First read beat arrives with the response itself.
                            r_beat_cnt <= c_one;
                            r_state    <= RD_BEATS;
                        end
                    end
                end
                RD_BEATS: begin
                    r_beat_cnt <= r_beat_cnt + c_one;
                    if (r_beat_cnt == c_last_beat) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_gnt      = 2'b00;
        mem_cmd_out  = c_nop;
        mem_data_out = '0;
        req0_rsp_cmd = c_nop;
        req0_rdata   = '0;
        req1_rsp_cmd = c_nop;
        req1_rdata   = '0;
        case (r_state)
            CMD: begin
                req_gnt      = {r_owner, ~r_owner};
                mem_cmd_out  = r_cmd_q;
                mem_data_out = r_beat0_q;
            end
            WR_BEATS: begin
                mem_data_out = r_owner ? req1_wdata : req0_wdata;
            end
            WAIT_RESP, RD_BEATS: begin
                if (r_owner) begin
                    req1_rsp_cmd = (mem_cmd_in == c_response) ? c_response : c_nop;
                    req1_rdata   = mem_data_in;
                end else begin
                    req0_rsp_cmd = (mem_cmd_in == c_response) ? c_response : c_nop;
                    req0_rdata   = mem_data_in;
                end
            end
            default: ;
        endcase
    end

    assign busy        = (r_state != IDLE);
    assign mem_address = r_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter - directed stimulus with a transaction-timeline model
// Rev 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int LB = 8;
    localparam logic [1:0] NOP = 2'd0, RSP = 2'd1, RD = 2'd2, WR = 2'd3;

    logic        clk;
    logic        reset;
    logic [1:0]  r_cmd   [2];
    logic [14:0] r_addr  [2];
    logic [15:0] r_wdata [2];
    logic [1:0]  r_mem_cmd;
    logic [15:0] r_mem_data;

    logic [1:0]  w_gnt;
    logic [1:0]  w_rsp   [2];
    logic [15:0] w_rdata [2];
    logic        w_busy;
    logic [1:0]  w_mem_cmd;
    logic [14:0] w_mem_addr;
    logic [15:0] w_mem_data;

    int n_chk  = 0;
    int n_fail = 0;

    mem_bus_arbiter #(.BUS_SIZE(16), .ADDR_W(15), .LINE_BEATS(LB)) dut (
        .clk(clk), .reset(reset),
        .req0_cmd(r_cmd[0]), .req0_addr(r_addr[0]), .req0_wdata(r_wdata[0]),
        .req1_cmd(r_cmd[1]), .req1_addr(r_addr[1]), .req1_wdata(r_wdata[1]),
        .req_gnt(w_gnt),
        .req0_rsp_cmd(w_rsp[0]), .req0_rdata(w_rdata[0]),
        .req1_rsp_cmd(w_rsp[1]), .req1_rdata(w_rdata[1]),
        .busy(w_busy), .mem_cmd_out(w_mem_cmd), .mem_address(w_mem_addr),
        .mem_data_out(w_mem_data), .mem_cmd_in(r_mem_cmd), .mem_data_in(r_mem_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one transaction record, timed as cycles since its command cycle.
    bit          m_valid = 0, m_active = 0, m_owner = 0, m_last = 1;
    logic [1:0]  m_cmd = NOP;
    logic [14:0] m_addr = '0;
    logic [15:0] m_beat0 = '0;
    int          m_k = 0, m_beats = 0;

    task automatic model_step();
        bit v0, v1, w;
        if (reset == 1'b0) begin
            m_valid = 1; m_active = 0; m_owner = 0; m_last = 1;
            m_cmd = NOP; m_addr = '0; m_beat0 = '0;
        end else if (!m_active) begin
            v0 = (r_cmd[0] == RD) || (r_cmd[0] == WR);
            v1 = (r_cmd[1] == RD) || (r_cmd[1] == WR);
            if (v0 || v1) begin
                w = (v0 && v1) ? !m_last : v1;
                m_owner = w; m_last = w; m_cmd = r_cmd[w]; m_addr = r_addr[w];
                m_beat0 = r_wdata[w]; m_active = 1; m_k = 0; m_beats = 0;
            end
        end else begin
            if (m_cmd == WR) begin
                if (m_k >= LB && r_mem_cmd == RSP) m_active = 0;
            end else if (m_k >= 1) begin
                if (m_beats > 0 || r_mem_cmd == RSP) m_beats++;
                if (m_beats == LB) m_active = 0;
            end
            m_k++;
        end
    endtask

    task automatic compare();
        logic [1:0]  e_gnt, e_mcmd;
        logic [15:0] e_mdata;
        logic [1:0]  e_rsp [2];
        logic [15:0] e_rd  [2];
        e_gnt = 2'b00; e_mcmd = NOP; e_mdata = '0;
        e_rsp[0] = NOP; e_rsp[1] = NOP; e_rd[0] = '0; e_rd[1] = '0;
        if (m_active) begin
            if (m_k == 0) begin
                e_gnt[m_owner] = 1'b1; e_mcmd = m_cmd; e_mdata = m_beat0;
            end else if (m_cmd == WR && m_k < LB) begin
                e_mdata = r_wdata[m_owner];
            end else begin
                e_rsp[m_owner] = (r_mem_cmd == RSP) ? RSP : NOP;
                e_rd[m_owner]  = r_mem_data;
            end
        end
        chk("model_gnt", w_gnt, e_gnt);
        chk("model_mem_cmd", w_mem_cmd, e_mcmd);
        chk("model_mem_data", w_mem_data, e_mdata);
        chk("model_mem_addr", w_mem_addr, m_addr);
        chk("model_busy", w_busy, m_active);
        for (int i = 0; i < 2; i++) begin
            chk("model_rsp_cmd", w_rsp[i], e_rsp[i]);
            chk("model_rdata", w_rdata[i], e_rd[i]);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) compare();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for requester n's grant, checks the command phase, drops the request.
    task automatic wait_gnt(input int n, input logic [1:0] cmd, input logic [14:0] addr);
        int t;
        t = 0;
        @(negedge clk);
        while (!w_gnt[n] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("gnt_seen", w_gnt, (n == 0) ? 2'b01 : 2'b10);
        chk("cmd_phase_cmd", w_mem_cmd, cmd);
        chk("cmd_phase_addr", w_mem_addr, addr);
        chk("cmd_phase_data", w_mem_data, r_wdata[n]);
        cyc();
        r_cmd[n] = NOP;
    endtask

    // Entered at the cycle after CMD; memory answers 'delay' cycles after CMD.
    task automatic serve_read(input int n, input int delay, input logic [15:0] base,
                              input int raise_beat);
        r_mem_data = 16'h5A5A;
        repeat (delay - 1) cyc();
        for (int b = 0; b < LB; b++) begin
            r_mem_cmd  = RSP;
            r_mem_data = base + 16'(b);
            if (b == raise_beat) begin
                r_cmd[1] = RD; r_addr[1] = 15'h0777; r_wdata[1] = '0;
            end
            @(negedge clk);
            chk("rd_rsp_cmd", w_rsp[n], RSP);
            chk("rd_rdata", w_rdata[n], base + 16'(b));
            chk("rd_other_rsp", w_rsp[1-n], NOP);
            cyc();
        end
        r_mem_cmd = NOP; r_mem_data = '0;
        @(negedge clk);
        chk("rd_done_busy", w_busy, 1'b0);
        chk("rd_done_gnt", w_gnt, 2'b00);
        cyc();
    endtask

    task automatic do_write(input int n, input logic [14:0] addr, input logic [15:0] base,
                            input int delay, input int rst_beat);
        r_cmd[n] = WR; r_addr[n] = addr; r_wdata[n] = base;
        wait_gnt(n, WR, addr);
        for (int k = 1; k < LB; k++) begin
            r_wdata[n] = base + 16'(k);
            if (k == rst_beat) reset = 1'b0;
            @(negedge clk);
            chk("wr_beat", w_mem_data, base + 16'(k));
            cyc();
            if (k == rst_beat) begin
                reset = 1'b1;
                @(negedge clk);
                chk("rst_mem_cmd", w_mem_cmd, NOP);
                chk("rst_mem_data", w_mem_data, 16'h0000);
                chk("rst_busy", w_busy, 1'b0);
                cyc();
                return;
            end
        end
        r_mem_data = 16'h5A5A;
        repeat (delay - 1) cyc();
        r_mem_cmd = RSP; r_mem_data = '0;
        @(negedge clk);
        chk("wr_rsp_cmd", w_rsp[n], RSP);
        cyc();
        r_mem_cmd = NOP;
        @(negedge clk);
        chk("wr_done_busy", w_busy, 1'b0);
        cyc();
    endtask

    initial begin
        reset = 1'b0; r_mem_cmd = NOP; r_mem_data = '0;
        for (int i = 0; i < 2; i++) begin
            r_cmd[i] = NOP; r_addr[i] = '0; r_wdata[i] = '0;
        end
        repeat (2) cyc();
        @(negedge clk);
        chk("reset_busy", w_busy, 1'b0);
        chk("reset_mem_addr", w_mem_addr, 15'h0000);
        reset = 1'b1;
        cyc();

        // Single read by requester 0
        r_cmd[0] = RD; r_addr[0] = 15'h1234;
        wait_gnt(0, RD, 15'h1234);
        serve_read(0, 5, 16'h1000, -1);

        // Single write by requester 1
        do_write(1, 15'h0042, 16'h00A0, 3, -1);

        // Continuous tie after reset alternates 0,1,0,1
        reset = 1'b0; cyc(); reset = 1'b1;
        r_cmd[0] = RD; r_addr[0] = 15'h0010;
        r_cmd[1] = RD; r_addr[1] = 15'h0020;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(i % 2, RD, (i % 2 == 0) ? 15'h0010 : 15'h0020);
            r_cmd[i % 2] = (i < 2) ? RD : NOP;
            if (i == 3) r_cmd[0] = NOP;
            serve_read(i % 2, 2, 16'h3000 + 16'(i * 16), -1);
        end

        // Request arriving mid-transaction waits for IDLE then CMD
        r_cmd[0] = RD; r_addr[0] = 15'h0300;
        wait_gnt(0, RD, 15'h0300);
        serve_read(0, 2, 16'h2000, 2);
        @(negedge clk);
        chk("late_gnt_timing", w_gnt, 2'b10);
        chk("late_gnt_addr", w_mem_addr, 15'h0777);
        cyc();
        r_cmd[1] = NOP;
        serve_read(1, 3, 16'h2100, -1);

        // Reset during a write's beat 3, then a tie goes to requester 0
        do_write(0, 15'h0011, 16'h00B0, 2, 3);
        r_cmd[0] = RD; r_addr[0] = 15'h0100; r_wdata[0] = '0;
        r_cmd[1] = WR; r_addr[1] = 15'h0200; r_wdata[1] = 16'h00C0;
        wait_gnt(0, RD, 15'h0100);
        serve_read(0, 2, 16'h4000, -1);
        do_write(1, 15'h0200, 16'h00C0, 2, -1);

        // Non-request commands and stray memory responses while IDLE
        r_cmd[0] = RSP; r_cmd[1] = NOP; r_mem_cmd = RSP; r_mem_data = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_gnt", w_gnt, 2'b00);
            chk("idle_rsp0", w_rsp[0], NOP);
            chk("idle_rdata0", w_rdata[0], 16'h0000);
            chk("idle_mem_cmd", w_mem_cmd, NOP);
            cyc();
        end
        r_cmd[0] = NOP; r_mem_cmd = NOP; r_mem_data = '0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
